// File: rtl/jtag_tap_slave.sv
// IEEE 1149.1 TAP responder: oversamples the JTAG pins in the clk_i domain and runs the
// TAP controller with a 4-bit IR, IDCODE, BYPASS and one USER data register.
module jtag_tap_slave #(
    parameter logic [31:0] IDCODE = 32'h2000_0C93,
    parameter int          USER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jtag_tck_i,
    input  logic              jtag_tms_i,
    input  logic              jtag_tdi_i,
    input  logic              jtag_trst_i,
    output logic              jtag_tdo_o,
    output logic              jtag_tdo_en_o,
    output logic [3:0]        tap_state_o,
    output logic [3:0]        ir_o,
    input  logic [USER_W-1:0] user_capture_i,
    output logic [USER_W-1:0] user_dr_o,
    output logic              user_update_o
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [3:0] IR_IDCODE = 4'h1;
    localparam logic [3:0] IR_USER   = 4'h8;

    logic [1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic       tck_prev;
    logic       tms_s, tdi_s, trst_n_s;
    logic       tck_rise, tck_fall;

    tap_state_e  state, next_state;
    logic [3:0]  ir_sr;
    logic [3:0]  ir_q;
    logic [31:0] id_sr;
    logic [USER_W-1:0] user_sr;
    logic        byp;
    logic        dr_lsb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_sync  <= 2'b00;
            tms_sync  <= 2'b00;
            tdi_sync  <= 2'b00;
            trst_sync <= 2'b11;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], jtag_tck_i};
            tms_sync  <= {tms_sync[0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[0], jtag_tdi_i};
            trst_sync <= {trst_sync[0], jtag_trst_i};
            tck_prev  <= tck_sync[1];
        end
    end

    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];
    assign trst_n_s = trst_sync[1];
    // TCK edges are masked while TRST holds the controller in reset.
    assign tck_rise = trst_n_s &  tck_sync[1] & ~tck_prev;
    assign tck_fall = trst_n_s & ~tck_sync[1] &  tck_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          state <= TLR;
        else if (!trst_n_s) state <= TLR;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (tck_rise) begin
            case (state)
                TLR:    next_state = tms_s ? TLR    : RTI;
                RTI:    next_state = tms_s ? SEL_DR : RTI;
                SEL_DR: next_state = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: next_state = tms_s ? EX1_DR : SH_DR;
                SH_DR:  next_state = tms_s ? EX1_DR : SH_DR;
                EX1_DR: next_state = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: next_state = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: next_state = tms_s ? UPD_DR : SH_DR;
                UPD_DR: next_state = tms_s ? SEL_DR : RTI;
                SEL_IR: next_state = tms_s ? TLR    : CAP_IR;
                CAP_IR: next_state = tms_s ? EX1_IR : SH_IR;
                SH_IR:  next_state = tms_s ? EX1_IR : SH_IR;
                EX1_IR: next_state = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: next_state = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: next_state = tms_s ? UPD_IR : SH_IR;
                UPD_IR: next_state = tms_s ? SEL_DR : RTI;
                default: next_state = TLR;
            endcase
        end
    end

    // Any IR value other than IDCODE or USER routes the 1-bit bypass register.
    always_comb begin
        dr_lsb = byp;
        if (ir_q == IR_IDCODE)    dr_lsb = id_sr[0];
        else if (ir_q == IR_USER) dr_lsb = user_sr[0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_sr         <= 4'h0;
            ir_q          <= IR_IDCODE;
            id_sr         <= 32'h0;
            user_sr       <= '0;
            byp           <= 1'b0;
            user_dr_o     <= '0;
            user_update_o <= 1'b0;
            jtag_tdo_o    <= 1'b0;
            jtag_tdo_en_o <= 1'b0;
        end else begin
            user_update_o <= 1'b0;
            if (!trst_n_s) begin
                ir_q <= IR_IDCODE;
            end else if (tck_rise) begin
                case (state)
                    TLR:    ir_q  <= IR_IDCODE;
                    CAP_IR: ir_sr <= 4'b0101;
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[3:1]};
                    UPD_IR: ir_q  <= ir_sr;
                    CAP_DR: begin
                        if (ir_q == IR_IDCODE)    id_sr   <= IDCODE;
                        else if (ir_q == IR_USER) user_sr <= user_capture_i;
                        else                      byp     <= 1'b0;
                    end
                    SH_DR: begin
                        if (ir_q == IR_IDCODE)    id_sr   <= {tdi_s, id_sr[31:1]};
                        else if (ir_q == IR_USER) user_sr <= {tdi_s, user_sr[USER_W-1:1]};
                        else                      byp     <= tdi_s;
                    end
                    UPD_DR: begin
                        if (ir_q == IR_USER) begin
                            user_dr_o     <= user_sr;
                            user_update_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (tck_fall) begin
                if (state == SH_IR) begin
                    jtag_tdo_o    <= ir_sr[0];
                    jtag_tdo_en_o <= 1'b1;
                end else if (state == SH_DR) begin
                    jtag_tdo_o    <= dr_lsb;
                    jtag_tdo_en_o <= 1'b1;
                end else begin
                    jtag_tdo_o    <= 1'b0;
                    jtag_tdo_en_o <= 1'b0;
                end
            end
        end
    end

    assign tap_state_o = state;
    assign ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed bench for jtag_tap_slave: a table of TMS navigation vectors plus hand-written
// IDCODE, IR, USER, TRST and pause/resume scans with hand-computed expectations.
module tb_jtag_tap_slave;

    localparam int USER_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              jtag_tck, jtag_tms, jtag_tdi, jtag_trst;
    logic              jtag_tdo_o, jtag_tdo_en_o;
    logic [3:0]        tap_state_o, ir_o;
    logic [USER_W-1:0] user_capture, user_dr_o;
    logic              user_update_o;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
    } nav_vec_t;

    nav_vec_t nav_tab[23];

    jtag_tap_slave #(.IDCODE(32'h2000_0C93), .USER_W(USER_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .jtag_tck_i     (jtag_tck),
        .jtag_tms_i     (jtag_tms),
        .jtag_tdi_i     (jtag_tdi),
        .jtag_trst_i    (jtag_trst),
        .jtag_tdo_o     (jtag_tdo_o),
        .jtag_tdo_en_o  (jtag_tdo_en_o),
        .tap_state_o    (tap_state_o),
        .ir_o           (ir_o),
        .user_capture_i (user_capture),
        .user_dr_o      (user_dr_o),
        .user_update_o  (user_update_o)
    );

    always #5 clk = ~clk;

    // Counts clk_i cycles with the update strobe high.
    always @(negedge clk) if (user_update_o) upd_cnt <= upd_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One TCK period: TDO/TDO_EN sampled before the rise, state sampled after it.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_smp,
                             output logic en_smp, output logic [3:0] st_smp);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (6) @(negedge clk);
        tdo_smp  = jtag_tdo_o;
        en_smp   = jtag_tdo_en_o;
        jtag_tck = 1'b1;
        repeat (6) @(negedge clk);
        st_smp   = tap_state_o;
        jtag_tck = 1'b0;
    endtask

    task automatic step(input logic tms, output logic [3:0] st);
        logic d, e;
        tck_cycle(tms, 1'b0, d, e, st);
    endtask

    // From Shift-DR/IR: shift n bits LSB first, TMS high on the last bit (ends in Exit1).
    task automatic shift_bits(input logic [31:0] data, input int n, output logic [31:0] tdo_bits,
                              output int n_shift_state);
        logic t, e;
        logic [3:0] st;
        tdo_bits = '0;
        n_shift_state = 0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, data[i], t, e, st);
            tdo_bits[i] = t;
            if (st == 4'h2 || st == 4'hA) n_shift_state++;
        end
    endtask

    // From RTI: load a new instruction and return to RTI; returns the captured IR bits.
    task automatic ir_scan(input logic [3:0] ir_val, output logic [3:0] cap);
        logic [3:0]  st;
        logic [31:0] bits;
        int          ns;
        step(1'b1, st); step(1'b1, st); step(1'b0, st); step(1'b0, st);
        shift_bits({28'h0, ir_val}, 4, bits, ns);
        cap = bits[3:0];
        step(1'b1, st); step(1'b0, st);
    endtask

    logic [3:0]  st, cap4;
    logic [31:0] bits, saved_dr;
    logic        t, e;
    int          ns, upd_before;

    initial begin
        nav_tab = '{
            '{1'b0, 4'hC}, '{1'b1, 4'h7}, '{1'b0, 4'h6}, '{1'b1, 4'h1},
            '{1'b0, 4'h3}, '{1'b0, 4'h3}, '{1'b1, 4'h0}, '{1'b0, 4'h2},
            '{1'b1, 4'h1}, '{1'b1, 4'h5}, '{1'b1, 4'h7}, '{1'b1, 4'h4},
            '{1'b0, 4'hE}, '{1'b1, 4'h9}, '{1'b0, 4'hB}, '{1'b1, 4'h8},
            '{1'b0, 4'hA}, '{1'b1, 4'h9}, '{1'b1, 4'hD}, '{1'b0, 4'hC},
            '{1'b1, 4'h7}, '{1'b1, 4'h4}, '{1'b1, 4'hF}
        };

        rst = 1'b1; jtag_tck = 1'b0; jtag_tms = 1'b0; jtag_tdi = 1'b0; jtag_trst = 1'b0;
        user_capture = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        check("reset_state", {28'h0, tap_state_o}, 32'hF);
        check("reset_ir", {28'h0, ir_o}, 32'h1);
        check("reset_tdo", {30'h0, jtag_tdo_en_o, jtag_tdo_o}, 32'h0);
        check("reset_user", {user_dr_o[30:0], user_update_o}, 32'h0);
        rst = 1'b0;
        jtag_trst = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_release_state", {28'h0, tap_state_o}, 32'hF);

        for (int i = 0; i < 23; i++) begin
            step(nav_tab[i].tms, st);
            check($sformatf("nav_%0d", i), {28'h0, st}, {28'h0, nav_tab[i].exp_state});
        end

        // Five TMS=1 rises from Shift-DR reach Test-Logic-Reset.
        step(1'b0, st); step(1'b1, st); step(1'b0, st); step(1'b0, st);
        check("to_shdr", {28'h0, st}, 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, st);
        check("five_tms_tlr", {28'h0, st}, 32'hF);

        // IDCODE readback.
        step(1'b0, st); check("id_rti", {28'h0, st}, 32'hC);
        step(1'b1, st); check("id_seldr", {28'h0, st}, 32'h7);
        step(1'b0, st); check("id_capdr", {28'h0, st}, 32'h6);
        step(1'b0, st); check("id_shdr", {28'h0, st}, 32'h2);
        tck_cycle(1'b0, 1'b0, t, e, st);
        check("id_tdo_en", {31'h0, e}, 32'h1);
        bits[0] = t;
        begin
            logic [31:0] rest;
            shift_bits(32'h0, 31, rest, ns);
            bits[31:1] = rest[30:0];
        end
        check("id_value", bits, 32'h2000_0C93);
        check("id_shift_states", ns, 32'd30);
        check("id_ex1dr", {28'h0, tap_state_o}, 32'h1);
        step(1'b1, st); step(1'b0, st);

        // IR scan of 4'hF: capture pattern out, then bypass delays DR data by one bit.
        ir_scan(4'hF, cap4);
        check("ir_capture", {28'h0, cap4}, 32'h5);
        check("ir_after_upd", {28'h0, ir_o}, 32'hF);
        step(1'b1, st); step(1'b0, st); step(1'b0, st);
        shift_bits(32'hD, 4, bits, ns);
        check("bypass_delay", bits, 32'hA);
        check("ir_stable_dr", {28'h0, ir_o}, 32'hF);
        step(1'b1, st); step(1'b0, st);

        // USER capture/update.
        ir_scan(4'h8, cap4);
        check("ir_user", {28'h0, ir_o}, 32'h8);
        upd_before = upd_cnt;
        step(1'b1, st); step(1'b0, st); step(1'b0, st);
        shift_bits(32'h1234_5678, 32, bits, ns);
        check("user_capture", bits, 32'hDEAD_BEEF);
        check("user_no_early_upd", upd_cnt - upd_before, 32'd0);
        step(1'b1, st); check("user_upddr", {28'h0, st}, 32'h5);
        step(1'b0, st);
        check("user_dr", user_dr_o, 32'h1234_5678);
        check("user_pulse", upd_cnt - upd_before, 32'd1);

        // TRST asserted mid Shift-DR.
        saved_dr = user_dr_o;
        upd_before = upd_cnt;
        step(1'b1, st); step(1'b0, st); step(1'b0, st);
        tck_cycle(1'b0, 1'b1, t, e, st); tck_cycle(1'b0, 1'b0, t, e, st);
        check("trst_pre_state", {28'h0, st}, 32'h2);
        repeat (6) @(negedge clk);
        jtag_trst = 1'b0;
        repeat (3) @(negedge clk);
        check("trst_state", {28'h0, tap_state_o}, 32'hF);
        check("trst_ir", {28'h0, ir_o}, 32'h1);
        jtag_trst = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_user_dr", user_dr_o, saved_dr);
        check("trst_no_pulse", upd_cnt - upd_before, 32'd0);

        // Pause after 10 USER bits, hold 20 TCKs, resume through Exit2-DR.
        step(1'b0, st);
        ir_scan(4'h8, cap4);
        user_capture = 32'hA5C3_1E7F;
        upd_before = upd_cnt;
        step(1'b1, st); step(1'b0, st); step(1'b0, st);
        begin
            logic [31:0] first, second;
            shift_bits(32'h0F1E_2D3C, 10, first, ns);
            check("pause_ex1dr", {28'h0, tap_state_o}, 32'h1);
            step(1'b0, st); check("pause_enter", {28'h0, st}, 32'h3);
            ns = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b0, st);
                if (st == 4'h3) ns++;
            end
            check("pause_hold", ns, 32'd20);
            tck_cycle(1'b1, 1'b0, t, e, st);
            check("pause_tdo_en", {31'h0, e}, 32'h0);
            check("pause_ex2dr", {28'h0, st}, 32'h0);
            step(1'b0, st); check("pause_resume", {28'h0, st}, 32'h2);
            shift_bits(32'h0F1E_2D3C >> 10, 22, second, ns);
            bits = {second[21:0], first[9:0]};
        end
        check("pause_readback", bits, 32'hA5C3_1E7F);
        step(1'b1, st); step(1'b0, st);
        check("pause_user_dr", user_dr_o, 32'h0F1E_2D3C);
        check("pause_pulse", upd_cnt - upd_before, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
